// File: rtl/seq_divider_pkg.sv
// Shared constants for the integer datapath: ALU/divider funct codes and divider FSM states.
// Also provides the two's-complement negation helper used for sign handling.
package seq_divider_pkg;

   localparam int unsigned WIDTH = 32;

   localparam logic [5:0] AND  = 6'b100100;
   localparam logic [5:0] OR   = 6'b100101;
   localparam logic [5:0] ADD  = 6'b100000;
   localparam logic [5:0] SUB  = 6'b100010;
   localparam logic [5:0] SLT  = 6'b101010;
   localparam logic [5:0] DIV  = 6'b011010;
   localparam logic [5:0] DIVU = 6'b011011;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the datapath controller (master) and the divider (slave).
interface seq_divider_if;
   import seq_divider_pkg::*;

   logic             start;
   logic [5:0]       Signal;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, Signal, dataA, dataB,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, Signal, dataA, dataB,
      output busy, done, quotient, remainder, div_zero
   );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when it is non-negative.
module seq_divider_div_step
   import seq_divider_pkg::*;
(
   input  logic [WIDTH:0]   prem,
   input  logic             msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   prem_next,
   output logic             qbit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      shifted   = {prem, msb};
      diff      = shifted[WIDTH:0] - {1'b0, divisor};
      qbit      = (shifted >= {2'b00, divisor});
      prem_next = qbit ? diff : shifted[WIDTH:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative 32-bit DIV/DIVU unit: one quotient bit per clock on magnitudes,
// signs re-applied when the last step registers the results.
module seq_divider
   import seq_divider_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] dvd, dvs, quot_r, rem_r;
   logic             neg_q, neg_r, busy_r, done_r, dz_r;

   logic             is_div, accept, sign_a, sign_b, qbit;
   logic [WIDTH-1:0] abs_a, abs_b, q_fin, r_fin;
   logic [WIDTH:0]   prem_next;

   assign is_div = (bus.Signal == DIV);
   assign accept = bus.start && (is_div || (bus.Signal == DIVU));
   assign sign_a = is_div & bus.dataA[WIDTH-1];
   assign sign_b = is_div & bus.dataB[WIDTH-1];
   assign abs_a  = sign_a ? negate(bus.dataA) : bus.dataA;
   assign abs_b  = sign_b ? negate(bus.dataB) : bus.dataB;

   // dvd doubles as the quotient shift register: dividend bits leave the top, quotient bits enter.
   assign q_fin  = {dvd[WIDTH-2:0], qbit};
   assign r_fin  = prem_next[WIDTH-1:0];

   seq_divider_div_step u_step (
      .prem      (prem),
      .msb       (dvd[WIDTH-1]),
      .divisor   (dvs),
      .prem_next (prem_next),
      .qbit      (qbit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         count  <= '0;
         prem   <= '0;
         dvd    <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
         quot_r <= '0;
         rem_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  busy_r <= 1'b1;
                  if (bus.dataB == '0) begin
                     quot_r <= '1;
                     rem_r  <= bus.dataA;
                     dz_r   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     dvd   <= abs_a;
                     dvs   <= abs_b;
                     neg_q <= sign_a ^ sign_b;
                     neg_r <= sign_a;
                     prem  <= '0;
                     count <= CW'(WIDTH - 1);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               prem  <= prem_next;
               dvd   <= q_fin;
               count <= count - 1'b1;
               if (count == '0) begin
                  quot_r <= neg_q ? negate(q_fin) : q_fin;
                  rem_r  <= neg_r ? negate(r_fin) : r_fin;
                  dz_r   <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               // Divide-by-zero enters with done low so its pulse lands one cycle after acceptance.
               if (!done_r) begin
                  done_r <= 1'b1;
               end else begin
                  done_r <= 1'b0;
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.quotient  = quot_r;
   assign bus.remainder = rem_r;
   assign bus.div_zero  = dz_r;

endmodule
